fifo_controller: RTL

FIFO_CONTROLLER -- requirements
Module: fifo_controller

---
 rtl/fifo_controller_if.sv | 43 ++++
 rtl/fifo_controller.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fifo_controller_if.sv
// fifo_controller_if: groups every non-clock signal of the FIFO controller.
//   upstream   : push_in, data_in
//   downstream : pop_in, data_out, valid_out
//   thresholds : umbral_alto, umbral_bajo (taken once after reset)
//   memory     : wr_ptr, rd_ptr, push, pop, data_in_MM, data_out_MM
//   status     : full, empty, almost_full, almost_empty, count, error
// The master modport is the environment (source/sink plus memory); the slave modport is the controller.
interface fifo_controller_if #(
   parameter int WORD_SIZE = 10,
   parameter int PTR       = 3
);
   logic                 push_in;
   logic                 pop_in;
   logic [WORD_SIZE-1:0] data_in;
   logic [PTR-1:0]       umbral_alto;
   logic [PTR-1:0]       umbral_bajo;
   logic [WORD_SIZE-1:0] data_out_MM;
   logic [PTR-1:0]       wr_ptr;
   logic [PTR-1:0]       rd_ptr;
   logic                 push;
   logic                 pop;
   logic [WORD_SIZE-1:0] data_in_MM;
   logic [WORD_SIZE-1:0] data_out;
   logic                 valid_out;
   logic                 full;
   logic                 empty;
   logic                 almost_full;
   logic                 almost_empty;
   logic [PTR:0]         count;
   logic                 error;

   modport master (
      output push_in, pop_in, data_in, umbral_alto, umbral_bajo, data_out_MM,
      input  wr_ptr, rd_ptr, push, pop, data_in_MM, data_out, valid_out,
      input  full, empty, almost_full, almost_empty, count, error
   );

   modport slave (
      input  push_in, pop_in, data_in, umbral_alto, umbral_bajo, data_out_MM,
      output wr_ptr, rd_ptr, push, pop, data_in_MM, data_out, valid_out,
      output full, empty, almost_full, almost_empty, count, error
   );
endinterface

// File: rtl/fifo_controller.sv
// fifo_controller: pointer, occupancy and flag control for a FIFO built on an
// external memory with a registered read port.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high; returns to INIT with the FIFO emptied
//   bus   : fifo_controller_if.slave -- request/data inputs, thresholds,
//           memory address/strobe/data, occupancy flags, count and sticky error
module fifo_controller #(
   parameter int MEM_SIZE  = 8,
   parameter int WORD_SIZE = 10,
   parameter int PTR       = 3
) (
   input  logic             clk,
   input  logic             reset,
   fifo_controller_if.slave bus
);
   localparam int               CNT_W    = PTR + 1;
   localparam logic [PTR-1:0]   PTR_LAST = PTR'(MEM_SIZE - 1);
   localparam logic [PTR-1:0]   PTR_ONE  = PTR'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MEM_SIZE);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      INIT   = 2'd0,
      IDLE   = 2'd1,
      ACTIVE = 2'd2,
      ERROR  = 2'd3
   } state_t;

   state_t           state_q;
   logic             error_q;
   logic             valid_out_q;
   logic [PTR-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR-1:0]   alto_q, bajo_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             run_s, full_s, empty_s, push_s, pop_s, overflow_s, underflow_s;

   // Occupancy flags, qualified memory strobes and error conditions
   always_comb begin
      run_s       = (state_q == IDLE) || (state_q == ACTIVE);
      full_s      = (count_q == CNT_FULL);
      empty_s     = (count_q == {CNT_W{1'b0}});
      pop_s       = bus.pop_in && !empty_s && run_s;
      // a pop in the same cycle frees the slot, so a push while full is still legal
      push_s      = bus.push_in && (!full_s || pop_s) && run_s;
      overflow_s  = run_s && bus.push_in && full_s && !bus.pop_in;
      underflow_s = run_s && bus.pop_in && empty_s;
   end

   // Next pointer and occupancy values
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR{1'b0}} : (wr_ptr_q + PTR_ONE);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR{1'b0}} : (rd_ptr_q + PTR_ONE);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Control FSM: threshold capture, idle/active tracking and sticky error
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= INIT;
         error_q <= 1'b0;
         // all-ones keeps almost_full low while the FIFO is empty before capture
         alto_q  <= {PTR{1'b1}};
         bajo_q  <= {PTR{1'b0}};
      end else begin
         case (state_q)
            INIT: begin
               alto_q  <= bus.umbral_alto;
               bajo_q  <= bus.umbral_bajo;
               state_q <= IDLE;
            end
            IDLE: begin
               if (overflow_s || underflow_s) begin
                  state_q <= ERROR;
                  error_q <= 1'b1;
               end else if (push_s) begin
                  state_q <= ACTIVE;
               end else begin
                  state_q <= IDLE;
               end
            end
            ACTIVE: begin
               if (overflow_s || underflow_s) begin
                  state_q <= ERROR;
                  error_q <= 1'b1;
               end else if (count_d == {CNT_W{1'b0}}) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= ACTIVE;
               end
            end
            ERROR: begin
               state_q <= ERROR;
               error_q <= 1'b1;
            end
            default: begin
               state_q <= ERROR;
               error_q <= 1'b1;
            end
         endcase
      end
   end

   // Pointers, occupancy and read-valid registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= {PTR{1'b0}};
         rd_ptr_q    <= {PTR{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         valid_out_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         valid_out_q <= pop_s;
      end
   end

   assign bus.wr_ptr       = wr_ptr_q;
   assign bus.rd_ptr       = rd_ptr_q;
   assign bus.push         = push_s;
   assign bus.pop          = pop_s;
   assign bus.data_in_MM   = bus.data_in;
   // the memory read register already holds the popped word in the valid cycle
   assign bus.data_out     = valid_out_q ? bus.data_out_MM : {WORD_SIZE{1'b0}};
   assign bus.valid_out    = valid_out_q;
   assign bus.full         = full_s;
   assign bus.empty        = empty_s;
   assign bus.almost_full  = (count_q >= {1'b0, alto_q}) && !full_s;
   assign bus.almost_empty = (count_q <= {1'b0, bajo_q}) && !empty_s;
   assign bus.count        = count_q;
   assign bus.error        = error_q;
endmodule
